event_encoder_8to3: RTL and testbench
=====================================

Name: event_encoder_8to3

Overview:
- Sequential 8-to-3 encoder; the reverse direction of the team's 3-to-8 one-hot decoder.
- Captures 8 event request lines into a pending register.
- Emits the binary index of each pending event, one per handshake, lowest index first.
- Sits between event sources (one line per source) and a consumer that expects 3-bit codes with valid/ready flow control.

Parameters:
- WIDTH, 8, number of event lines; only 8 supported.
- CODE_W, 3, code width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  capture enable; when 0, din is ignored.
- din  input  8  event lines; a bit high in a cycle = one event for that index.
- dout  output  3  encoded index of the presented event.
- dout_valid  output  1  dout holds a valid code.
- dout_ready  input  1  consumer accepts when dout_valid & dout_ready at a rising edge.
- pending_cnt  output  4  popcount of the pending register (0..8).
- busy  output  1  (pending != 0) | dout_valid.

Behaviour:
- Reset (async, rst_n=0): pending=8'h00, dout=3'd0, dout_valid=0; pending_cnt=0 and busy=0 follow combinationally. Deassertion is synchronous to clk (external synchronizer); no event is taken in the first cycle after release unless present on din.
- Pending update per edge: pending <= (pending & ~clr_mask) | (enable ? din : 8'h00).
  - clr_mask is the one-hot of the index loaded into dout this edge, or 0 if nothing is loaded.
  - Set wins over clear: an event on the bit being cleared in the same cycle stays pending.
- Output FSM, two states:
  - IDLE (dout_valid=0): if pending != 0, go to HOLD; load dout = lowest set index of pending; clear that bit.
  - HOLD (dout_valid=1):
    - dout_ready=0: hold dout and dout_valid stable.
    - dout_ready=1 and pending != 0: stay in HOLD; load the next lowest index in the same edge. This gives back-to-back throughput of one code per cycle.
    - dout_ready=1 and pending == 0: go to IDLE; dout keeps its last value.
- Load decisions use the registered pending, not din. Latency: din high at edge N -> pending at N -> dout_valid at N+1 (two clocks from sample to presentation).
- Priority: strictly lowest index first among bits pending at the load edge. A lower-index event arriving later overtakes older higher-index ones.
- Duplicate event on an already-pending bit (not being cleared): merged; only one code is emitted.
- enable=0: capture stops; already-pending events continue to drain normally.
- din=8'h00 or enable=0 with pending=0: no state change.
- All-ones input: 8 codes 0..7 emitted in order, one per accepted cycle.
- pending_cnt excludes the code currently held in dout.

Optional Feature:
- Macro ENC_OVERFLOW_EN.
- Defined:
  - Adds input ovf_clr (1 bit) and output ovf (1 bit, reset 0).
  - ovf sets sticky at the edge where any i has enable & din[i] & pending[i] & ~clr_mask[i], i.e. a merged duplicate.
  - ovf_clr=1 clears ovf; a set condition in the same cycle wins.
- Undefined: ports absent; duplicates merge silently; all other behaviour identical.

Test Plan:
- Reset mid-drain: din=8'hFF captured, then after 2 codes assert rst_n=0 asynchronously -> dout_valid=0, pending_cnt=0, busy=0 immediately, without waiting for a clock edge. After release, no codes emitted.
- Basic order: enable=1, dout_ready=1, one-cycle din=8'b1000_0100 -> dout=2 valid at edge 2, dout=7 at edge 3, dout_valid=0 at edge 4; pending_cnt 2,1,0,0.
- Backpressure: din=8'h03, dout_ready=0 -> dout=0 valid and stable for 5 cycles, pending_cnt=1. Then dout_ready=1 -> next edge dout=1, following edge dout_valid=0.
- Overtake and set-wins: din=8'h80, then while dout=7 is held, din=8'h01 -> next code is 0. Then pulse din[3] on the same edge bit 3 is loaded -> code 3 emitted twice in total.
- Enable gating: enable=0, din=8'hFF for 4 cycles -> no dout_valid, busy=0. Then enable=1, din=8'hFF for 1 cycle -> codes 0..7 on 8 consecutive cycles with dout_ready=1.
- ENC_OVERFLOW_EN: din=8'h10 on 2 consecutive cycles with dout_ready=0 -> ovf=1, exactly one code 4 emitted. ovf_clr pulse -> ovf=0.

Source files
------------

// File: rtl/event_encoder_8to3.sv
// rtl/event_encoder_8to3.sv - sequential 8-to-3 event encoder, lowest pending index first, valid/ready output
// Optional sticky duplicate-event flag (ovf/ovf_clr) when ENC_OVERFLOW_EN is defined.
module event_encoder_8to3 #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  din,
  output logic [CODE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CODE_W:0]   pending_cnt,
`ifdef ENC_OVERFLOW_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic              busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [WIDTH-1:0]  pending;
  logic [WIDTH-1:0]  set_mask;
  logic [WIDTH-1:0]  clr_mask;
  logic [CODE_W-1:0] low_idx;
  logic              load;

  // Scan downward so the lowest set bit is the last assignment to stick.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = CODE_W'(i);
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pending_cnt = pending_cnt + {{CODE_W{1'b0}}, pending[i]};
    end
  end

  // A new code is loaded whenever the output slot is empty or being freed this edge.
  assign load       = (|pending) && ((state == IDLE) || dout_ready);
  assign clr_mask   = load ? (WIDTH'(1) << low_idx) : '0;
  assign set_mask   = enable ? din : '0;
  assign dout_valid = (state == HOLD);
  assign busy       = (|pending) || dout_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= HOLD;
            dout  <= low_idx;
          end
        end
        HOLD: begin
          if (load) begin
            dout <= low_idx;
          end else if (dout_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENC_OVERFLOW_EN
  logic dup_hit;

  // A duplicate is an event landing on a bit that stays pending through this edge.
  assign dup_hit = |(set_mask & pending & ~clr_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (dup_hit) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb/tb_event_encoder_8to3.sv - scoreboard bench for event_encoder_8to3
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [3:0] pending_cnt;
  logic       busy;
`ifdef ENC_OVERFLOW_EN
  logic       ovf_clr = 1'b0;
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  event_encoder_8to3 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .din         (din),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .pending_cnt (pending_cnt),
`ifdef ENC_OVERFLOW_EN
    .ovf_clr     (ovf_clr),
    .ovf         (ovf),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every code the consumer accepts must be the next one the stimulus predicted.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_code", 32'(dout), 32'hFFFF);
      end else begin
        chk("code", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-drain
    enable = 1'b1;
    dout_ready = 1'b1;
    din = 8'hFF;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    tick();
    din = 8'h00;
    tick();
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_cnt", pending_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", busy, 0);
    drain_check("rst");

    // Basic order
    din = 8'b1000_0100;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd7);
    tick();
    din = 8'h00;
    chk("basic_cnt1", pending_cnt, 2);
    chk("basic_valid1", dout_valid, 0);
    tick();
    chk("basic_cnt2", pending_cnt, 1);
    chk("basic_valid2", dout_valid, 1);
    tick();
    chk("basic_cnt3", pending_cnt, 0);
    chk("basic_dout3", dout, 7);
    tick();
    chk("basic_cnt4", pending_cnt, 0);
    chk("basic_valid4", dout_valid, 0);
    chk("basic_dout_kept", dout, 7);
    drain_check("basic");

    // Backpressure
    dout_ready = 1'b0;
    din = 8'h03;
    tick();
    din = 8'h00;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", dout_valid, 1);
      chk("bp_dout", dout, 0);
      chk("bp_cnt", pending_cnt, 1);
      tick();
    end
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    dout_ready = 1'b1;
    tick();
    chk("bp_next", dout, 1);
    tick();
    chk("bp_idle", dout_valid, 0);
    drain_check("bp");

    // Overtake and set-wins
    dout_ready = 1'b0;
    din = 8'h80;
    tick();
    din = 8'h00;
    tick();
    chk("ovt_hold7", dout, 7);
    din = 8'h09;
    tick();
    din = 8'h00;
    chk("ovt_still7", dout, 7);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    dout_ready = 1'b1;
    tick();
    chk("ovt_overtake", dout, 0);
    din = 8'h08;
    tick();
    din = 8'h00;
    chk("setwin_dout", dout, 3);
    chk("setwin_cnt", pending_cnt, 1);
`ifdef ENC_OVERFLOW_EN
    chk("setwin_no_ovf", ovf, 0);
`endif
    tick();
    tick();
    chk("setwin_idle", dout_valid, 0);
    drain_check("ovt");

    // Enable gating, then all-ones burst
    enable = 1'b0;
    din = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("gate_valid", dout_valid, 0);
      chk("gate_busy", busy, 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
    tick();
    din = 8'h00;
    chk("burst_cnt", pending_cnt, 8);
    repeat (8) begin
      tick();
      chk("burst_valid", dout_valid, 1);
    end
    tick();
    chk("burst_idle", dout_valid, 0);
    chk("burst_busy", busy, 0);
    drain_check("burst");

`ifdef ENC_OVERFLOW_EN
    // Occupy the output with code 0 so bit 4 stays pending across both events.
    dout_ready = 1'b0;
    din = 8'h01;
    tick();
    din = 8'h00;
    tick();
    din = 8'h10;
    tick();
    chk("ovf_first", ovf, 0);
    tick();
    din = 8'h00;
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", pending_cnt, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd4);
    dout_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_idle", dout_valid, 0);
    drain_check("ovf");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
